// File: rtl/event_timestamp_capture.sv
// event_timestamp_capture: stamps edges of event_in with count_in and queues the
// stamps in a first-word fall-through FIFO drained over valid/ready.
// Optional build macro TS_BOTH_EDGES_EN: also capture falling edges (out_edge=0).
module event_timestamp_capture #(
    parameter int unsigned n     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [n-1:0]             count_in,
    input  logic                     event_in,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [n-1:0]             out_data,
    output logic                     out_edge,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic         rising;
        logic [n-1:0] stamp;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic             ev_d;
    logic             rise;
    logic             fall;
    logic             capture;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [LVL_W-1:0] level_nxt;
    entry_t           new_entry;
    entry_t           head_nxt;

    // Edge detection, push/pop arbitration and next head-of-queue selection.
    always_comb begin
        rise      = event_in & ~ev_d;
`ifdef TS_BOTH_EDGES_EN
        fall      = ~event_in & ev_d;
`else
        fall      = 1'b0;
`endif
        capture   = rise | fall;
        full      = (fifo_level == LVL_W'(DEPTH));
        pop       = out_valid & out_ready;
        push      = capture & (~full | pop);
        drop      = capture & full & ~pop;
        new_entry = '{rising: rise, stamp: count_in};
        rd_nxt    = pop ? PTR_W'(rd_ptr + 1'b1) : rd_ptr;
        level_nxt = fifo_level + LVL_W'(push) - LVL_W'(pop);
        // A push landing in the slot that becomes the head bypasses the array.
        head_nxt  = (push && (wr_ptr == rd_nxt)) ? new_entry : mem[rd_nxt];
    end

    // FIFO storage, pointers, registered head outputs and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ev_d       <= 1'b1;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_edge   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
            end
            rd_ptr     <= rd_nxt;
            ev_d       <= event_in;
            fifo_level <= level_nxt;
            out_valid  <= (level_nxt != '0);
            out_data   <= head_nxt.stamp;
            out_edge   <= head_nxt.rising;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
